reg_file_mp: RTL and testbench

- Parametrised successor to the single-port register file.
- Generic width and depth, NUM_RD independent read ports plus one write port.
- Per-bit write mask, write-to-read bypass, and a hardware bulk-clear sequencer.
- Sits beside the datapath as the general-purpose register store; read ports feed ALU operand muxes, the write port takes the writeback bus.

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_clr_ctrl.sv | 62 ++++++
 rtl/reg_file_mp.sv | 91 +++++++++
 tb/tb_reg_file_mp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// merge_mask lives in a class so its width can follow the instantiating WIDTH.
package reg_file_pkg;

  typedef enum bit [0:0] {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } rf_state_e;

  virtual class rf_mask #(parameter int W = 8);
    static function logic [W-1:0] merge_mask(input logic [W-1:0] old_v,
                                             input logic [W-1:0] new_v,
                                             input logic [W-1:0] mask);
      return (old_v & ~mask) | (new_v & mask);
    endfunction
  endclass

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// Bulk-clear sequencer: walks every register address once while busy is high.
//
//   state    | meaning
//   IDLE     | user reads/writes allowed, clr sampled
//   CLEARING | one register zeroed per cycle, user port locked out
module reg_file_clr_ctrl
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam bit [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_e   state;
  bit [AW-1:0] cnt;
  bit          busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state  <= CLEARING;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        CLEARING: begin
          if (cnt == LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state == CLEARING);
  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD registered read ports, one masked write port
// with write-to-read bypass, and a hardware bulk clear.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  parameter  int NUM_RD = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wen,
  input  logic [AW-1:0]           waddr,
  input  logic [WIDTH-1:0]        din,
  input  logic [WIDTH-1:0]        wmask,
  input  logic [NUM_RD-1:0]       oen,
  input  logic [NUM_RD*AW-1:0]    raddr,
  output logic [NUM_RD*WIDTH-1:0] dout,
  input  logic                    clr,
  output logic                    busy
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  bit   [WIDTH-1:0] regs [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             user_we;
  logic [WIDTH-1:0] wr_merged;

  reg_file_clr_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Out-of-range write addresses are dropped here, so nothing downstream sees them.
  always_comb begin
    user_we   = wen && !busy && ({1'b0, waddr} < DEPTH_W);
    wr_merged = '0;
    if (user_we) begin
      wr_merged = rf_mask#(WIDTH)::merge_mask(regs[waddr], din, wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (user_we) begin
      regs[waddr] <= wr_merged;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd_val;
    bit   [WIDTH-1:0] dout_q;

    assign ra = raddr[k*AW +: AW];

    // Same-cycle write to the read address forwards the merged value.
    always_comb begin
      rd_val = '0;
      if ({1'b0, ra} < DEPTH_W) begin
        rd_val = (user_we && (waddr == ra)) ? wr_merged : regs[ra];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (oen[k] && !busy) begin
        dout_q <= rd_val;
      end
    end

    assign dout[k*WIDTH +: WIDTH] = dout_q;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench: directed literal checks on an 8x8/2-port build, plus a model-checked
// randomized run on a 6-deep/3-port build.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  // build A: WIDTH=8, DEPTH=8, NUM_RD=2
  logic        wen_a = 0, clr_a = 0, busy_a;
  logic [2:0]  waddr_a = 0;
  logic [7:0]  din_a = 0, wmask_a = 0;
  logic [1:0]  oen_a = 0;
  logic [5:0]  raddr_a = 0;
  logic [15:0] dout_a;

  // build B: WIDTH=8, DEPTH=6, NUM_RD=3
  logic        wen_b = 0, clr_b = 0, busy_b;
  logic [2:0]  waddr_b = 0;
  logic [7:0]  din_b = 0, wmask_b = 0;
  logic [2:0]  oen_b = 0;
  logic [8:0]  raddr_b = 0;
  logic [23:0] dout_b;

  reg_file_mp #(.WIDTH(8), .DEPTH(8), .NUM_RD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .wen(wen_a), .waddr(waddr_a), .din(din_a),
    .wmask(wmask_a), .oen(oen_a), .raddr(raddr_a), .dout(dout_a),
    .clr(clr_a), .busy(busy_a)
  );

  reg_file_mp #(.WIDTH(8), .DEPTH(6), .NUM_RD(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .wen(wen_b), .waddr(waddr_b), .din(din_b),
    .wmask(wmask_b), .oen(oen_b), .raddr(raddr_b), .dout(dout_b),
    .clr(clr_b), .busy(busy_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of build B: array of registers, clear as a list of pending addresses.
  bit [7:0] m_regs [6];
  bit [7:0] m_dout [3];
  bit       m_busy;
  int       m_idx;

  initial begin
    int a;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 6; i++) m_regs[i] = 8'h00;
        for (int k = 0; k < 3; k++) m_dout[k] = 8'h00;
        m_busy = 1'b0;
        m_idx = 0;
      end else if (m_busy) begin
        m_regs[m_idx] = 8'h00;
        m_idx++;
        if (m_idx == 6) m_busy = 1'b0;
      end else begin
        a = int'(waddr_b);
        if (wen_b && a < 6)
          m_regs[a] = (m_regs[a] & ~wmask_b) | (din_b & wmask_b);
        for (int k = 0; k < 3; k++) begin
          if (oen_b[k]) begin
            a = int'(raddr_b[k*3 +: 3]);
            m_dout[k] = (a < 6) ? m_regs[a] : 8'h00;
          end
        end
        if (clr_b) begin
          m_busy = 1'b1;
          m_idx = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 3; k++)
          check($sformatf("b_dout%0d", k), 32'(dout_b[k*8 +: 8]), 32'(m_dout[k]));
        check("b_busy", 32'(busy_b), 32'(m_busy));
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_a", 32'(dout_a), 32'h0);
    check("rst_busy_a", 32'(busy_a), 32'h0);
    rst_n = 1'b1;
    started = 1'b1;

    // masked write then dual-port read of the same register
    wen_a = 1; waddr_a = 3; din_a = 8'hA5; wmask_a = 8'hFF;
    tick();
    wen_a = 0;
    check("t1_dout_before_read", 32'(dout_a), 32'h0);
    oen_a = 2'b11; raddr_a = {3'd3, 3'd3};
    tick();
    oen_a = 2'b00;
    check("t1_port0", 32'(dout_a[7:0]), 32'hA5);
    check("t1_port1", 32'(dout_a[15:8]), 32'hA5);

    // bypass plus mask
    wen_a = 1; waddr_a = 2; din_a = 8'hF0; wmask_a = 8'hFF;
    tick();
    din_a = 8'h0F; wmask_a = 8'h3C; oen_a = 2'b01; raddr_a = {3'd0, 3'd2};
    tick();
    wen_a = 0;
    check("t2_bypass", 32'(dout_a[7:0]), 32'hCC);
    check("t2_port1_hold", 32'(dout_a[15:8]), 32'hA5);
    tick();
    oen_a = 2'b00;
    check("t2_reread", 32'(dout_a[7:0]), 32'hCC);

    // fill, clear, locked-out write
    for (int i = 0; i < 8; i++) begin
      wen_a = 1; waddr_a = 3'(i); din_a = 8'((i + 1) * 17); wmask_a = 8'hFF;
      tick();
    end
    wen_a = 0;
    oen_a = 2'b11; raddr_a = {3'd7, 3'd5};
    tick();
    oen_a = 2'b00;
    check("t3_prefill_read", 32'(dout_a), 32'h8866);
    clr_a = 1;
    tick();
    clr_a = 0;
    check("t3_busy_rise", 32'(busy_a), 32'h1);
    wen_a = 1; waddr_a = 5; din_a = 8'hFF; wmask_a = 8'hFF;
    oen_a = 2'b11; raddr_a = {3'd0, 3'd0};
    n = 0;
    while (busy_a && n < 20) begin
      tick();
      n++;
    end
    wen_a = 0; oen_a = 2'b00;
    check("t3_busy_cycles", 32'(n), 32'd8);
    check("t3_dout_hold", 32'(dout_a), 32'h8866);
    for (int i = 0; i < 8; i++) begin
      oen_a = 2'b01; raddr_a = {3'd0, 3'(i)};
      tick();
      check($sformatf("t3_cleared_%0d", i), 32'(dout_a[7:0]), 32'h0);
    end
    oen_a = 2'b00;

    // reset in the middle of a clear
    wen_a = 1; waddr_a = 7; din_a = 8'h5A; wmask_a = 8'hFF;
    tick();
    wen_a = 0; oen_a = 2'b01; raddr_a = {3'd0, 3'd7};
    tick();
    oen_a = 2'b00;
    check("t5_pre", 32'(dout_a[7:0]), 32'h5A);
    clr_a = 1;
    tick();
    clr_a = 0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy_async", 32'(busy_a), 32'h0);
    check("t5_dout_async", 32'(dout_a), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    oen_a = 2'b11; raddr_a = {3'd6, 3'd7};
    tick();
    oen_a = 2'b00;
    check("t5_reg7_zero", 32'(dout_a[7:0]), 32'h0);
    check("t5_reg6_zero", 32'(dout_a[15:8]), 32'h0);
    clr_a = 1;
    tick();
    clr_a = 0;
    check("t5_clr_accepted", 32'(busy_a), 32'h1);
    n = 0;
    while (busy_a && n < 20) begin
      tick();
      n++;
    end
    check("t5_busy_cycles", 32'(n), 32'd8);

    // build B: out-of-range addresses on a non power-of-two depth
    for (int i = 0; i < 6; i++) begin
      wen_b = 1; waddr_b = 3'(i); din_b = 8'(8'h10 + i); wmask_b = 8'hFF;
      tick();
    end
    waddr_b = 7; din_b = 8'h77; oen_b = 3'b111; raddr_b = {3'd7, 3'd6, 3'd0};
    tick();
    waddr_b = 6;
    tick();
    wen_b = 0;
    check("t4_addr0", 32'(dout_b[7:0]), 32'h10);
    check("t4_addr6", 32'(dout_b[15:8]), 32'h0);
    check("t4_addr7", 32'(dout_b[23:16]), 32'h0);
    for (int i = 1; i < 6; i++) begin
      oen_b = 3'b001; raddr_b = {3'd0, 3'd0, 3'(i)};
      tick();
      check($sformatf("t4_addr%0d", i), 32'(dout_b[7:0]), 32'(8'h10 + i));
    end

    // randomized concurrent traffic on build B
    for (int c = 0; c < 10000; c++) begin
      wen_b   = 1'($urandom_range(1));
      waddr_b = 3'($urandom_range(7));
      din_b   = 8'($urandom);
      wmask_b = 8'($urandom);
      oen_b   = 3'($urandom_range(7));
      raddr_b = 9'($urandom);
      clr_b   = ($urandom_range(63) == 0);
      tick();
    end
    wen_b = 0; oen_b = 0; clr_b = 0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
